// File: rtl/inst_encoder_pkg.sv
// Shared RV32I encode/decode definitions: immediate-format selectors, NOP word,
// immediate range limits and the field bundle carried through the encoder.
package inst_encoder_pkg;

    localparam int unsigned INST_W = 32;

    localparam logic [2:0] IMMSEL_R   = 3'd0;
    localparam logic [2:0] IMMSEL_I   = 3'd1;
    localparam logic [2:0] IMMSEL_S   = 3'd2;
    localparam logic [2:0] IMMSEL_B   = 3'd3;
    localparam logic [2:0] IMMSEL_U   = 3'd4;
    localparam logic [2:0] IMMSEL_J   = 3'd5;
    localparam logic [2:0] IMMSEL_CSR = 3'd6;
    localparam logic [2:0] IMMSEL_ILL = 3'd7;

    localparam logic [INST_W-1:0] NOP_INST = 32'h0000_0013;

    // Signed immediate limits; B/J upper limits are the largest even offsets
    localparam logic signed [31:0] IMM12_MIN = -32'sd2048;
    localparam logic signed [31:0] IMM12_MAX = 32'sd2047;
    localparam logic signed [31:0] IMMB_MIN  = -32'sd4096;
    localparam logic signed [31:0] IMMB_MAX  = 32'sd4094;
    localparam logic signed [31:0] IMMJ_MIN  = -32'sd1048576;
    localparam logic signed [31:0] IMMJ_MAX  = 32'sd1048574;
    localparam logic [31:0]        ZIMM_MAX  = 32'd31;

    typedef struct packed {
        logic [2:0]  immsel;
        logic [6:0]  opcode;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [11:0] csr_addr;
        logic [31:0] imm;
    } fields_t;

endpackage

// File: rtl/inst_encoder_pack.sv
// Combinational immediate range check and type-specific bit scatter into a
// 32-bit RV32I instruction word.
module inst_encoder_pack
    import inst_encoder_pkg::*;
(
    input  fields_t           f,
    output logic [INST_W-1:0] inst,
    output logic              err
);

    logic signed [31:0] imm_s;

    assign imm_s = $signed(f.imm);

    always_comb begin
        inst = '0;
        err  = 1'b0;
        case (f.immsel)
            IMMSEL_R: begin
                inst = {f.funct7, f.rs2, f.rs1, f.funct3, f.rd, f.opcode};
            end
            IMMSEL_I: begin
                err  = (imm_s < IMM12_MIN) || (imm_s > IMM12_MAX);
                inst = {f.imm[11:0], f.rs1, f.funct3, f.rd, f.opcode};
            end
            IMMSEL_S: begin
                err  = (imm_s < IMM12_MIN) || (imm_s > IMM12_MAX);
                inst = {f.imm[11:5], f.rs2, f.rs1, f.funct3, f.imm[4:0], f.opcode};
            end
            IMMSEL_B: begin
                err  = (imm_s < IMMB_MIN) || (imm_s > IMMB_MAX) || f.imm[0];
                inst = {f.imm[12], f.imm[10:5], f.rs2, f.rs1, f.funct3,
                        f.imm[4:1], f.imm[11], f.opcode};
            end
            IMMSEL_U: begin
                err  = (f.imm[11:0] != 12'd0);
                inst = {f.imm[31:12], f.rd, f.opcode};
            end
            IMMSEL_J: begin
                err  = (imm_s < IMMJ_MIN) || (imm_s > IMMJ_MAX) || f.imm[0];
                inst = {f.imm[20], f.imm[10:1], f.imm[11], f.imm[19:12], f.rd, f.opcode};
            end
            IMMSEL_CSR: begin
                // zimm is zero-extended, so any bit above [4:0] is out of range
                err  = (f.imm > ZIMM_MAX);
                inst = {f.csr_addr, f.imm[4:0], f.funct3, f.rd, f.opcode};
            end
            default: begin
                inst = NOP_INST;
                err  = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/inst_encoder.sv
// Streaming RV32I instruction assembler: two-stage valid/ready pipeline
// (S1 holds the field bundle, S2 holds the packed word) plus hand-off counters.
module inst_encoder
    import inst_encoder_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        immsel,
    input  logic [6:0]        opcode,
    input  logic [4:0]        rd,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    input  logic [2:0]        funct3,
    input  logic [6:0]        funct7,
    input  logic [11:0]       csr_addr,
    input  logic [31:0]       imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [INST_W-1:0] out_inst,
    output logic              out_err,
    output logic [CNT_W-1:0]  enc_count,
    output logic [CNT_W-1:0]  err_count
);

    fields_t           in_f;
    fields_t           s1_f;
    logic              s1_valid;
    logic              adv1;
    logic              adv2;
    logic [INST_W-1:0] pack_inst;
    logic              pack_err;
    logic              out_hs;

    assign in_f = '{immsel: immsel, opcode: opcode, rd: rd, rs1: rs1, rs2: rs2,
                    funct3: funct3, funct7: funct7, csr_addr: csr_addr, imm: imm};

    // A stage advances when it is empty or the stage after it is draining
    assign adv2     = !out_valid || out_ready;
    assign adv1     = !s1_valid || adv2;
    assign in_ready = adv1;
    assign out_hs   = out_valid && out_ready;

    inst_encoder_pack u_pack (
        .f    (s1_f),
        .inst (pack_inst),
        .err  (pack_err)
    );

    // S1: field bundle register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_f     <= '0;
        end else if (adv1) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_f <= in_f;
            end
        end
    end

    // S2: packed word register; holds while stalled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_inst  <= '0;
            out_err   <= 1'b0;
        end else if (adv2) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_inst <= pack_inst;
                out_err  <= pack_err;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            enc_count <= '0;
            err_count <= '0;
        end else if (out_hs) begin
            enc_count <= enc_count + CNT_W'(1);
            err_count <= err_count + CNT_W'(out_err);
        end
    end

endmodule

// File: tb/tb_inst_encoder.sv
// Directed self-checking bench for inst_encoder: encodings, range errors,
// backpressure and asynchronous reset.
module tb_inst_encoder;

    localparam int unsigned CNT_W = 16;

    logic              clk;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        immsel;
    logic [6:0]        opcode;
    logic [4:0]        rd;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [2:0]        funct3;
    logic [6:0]        funct7;
    logic [11:0]       csr_addr;
    logic [31:0]       imm;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_inst;
    logic              out_err;
    logic [CNT_W-1:0]  enc_count;
    logic [CNT_W-1:0]  err_count;

    int n_cmp;
    int n_bad;

    inst_encoder #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .immsel    (immsel),
        .opcode    (opcode),
        .rd        (rd),
        .rs1       (rs1),
        .rs2       (rs2),
        .funct3    (funct3),
        .funct7    (funct7),
        .csr_addr  (csr_addr),
        .imm       (imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_inst  (out_inst),
        .out_err   (out_err),
        .enc_count (enc_count),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_f(input logic [2:0] sel, input logic [6:0] op, input logic [4:0] rd_v,
                         input logic [4:0] rs1_v, input logic [4:0] rs2_v, input logic [2:0] f3,
                         input logic [6:0] f7, input logic [11:0] csr, input logic [31:0] imm_v);
        immsel   = sel;
        opcode   = op;
        rd       = rd_v;
        rs1      = rs1_v;
        rs2      = rs2_v;
        funct3   = f3;
        funct7   = f7;
        csr_addr = csr;
        imm      = imm_v;
    endtask

    // One bundle through an idle pipeline with out_ready=1; called at posedge+1
    task automatic xact(input string tag, input logic [2:0] sel, input logic [6:0] op,
                        input logic [4:0] rd_v, input logic [4:0] rs1_v, input logic [4:0] rs2_v,
                        input logic [2:0] f3, input logic [6:0] f7, input logic [11:0] csr,
                        input logic [31:0] imm_v, input logic [31:0] exp_inst, input logic exp_err);
        set_f(sel, op, rd_v, rs1_v, rs2_v, f3, f7, csr, imm_v);
        in_valid = 1'b1;
        chk({tag, ".in_ready"}, 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk({tag, ".lat1"}, 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        chk({tag, ".valid"}, 32'(out_valid), 32'd1);
        chk({tag, ".inst"}, out_inst, exp_inst);
        chk({tag, ".err"}, 32'(out_err), 32'(exp_err));
        @(posedge clk); #1;
    endtask

    initial begin
        n_cmp     = 0;
        n_bad     = 0;
        clk       = 1'b0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        set_f(3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 12'd0, 32'd0);

        #12;
        chk("rst.out_valid", 32'(out_valid), 32'd0);
        chk("rst.out_inst", out_inst, 32'd0);
        chk("rst.out_err", 32'(out_err), 32'd0);
        chk("rst.enc_count", 32'(enc_count), 32'd0);
        chk("rst.err_count", 32'(err_count), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Legal encodings
        xact("I",     3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 12'd0, 32'hFFFF_FFFF, 32'hFFF00093, 1'b0);
        xact("S",     3'd2, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 12'd0, 32'd8,         32'h0020A423, 1'b0);
        xact("B",     3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 12'd0, 32'hFFFF_FFFC, 32'hFE000EE3, 1'b0);
        xact("U",     3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 12'd0, 32'h1234_5000, 32'h123452B7, 1'b0);
        xact("J",     3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 12'd0, 32'd8,         32'h008000EF, 1'b0);
        xact("R",     3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 12'd0, 32'hDEAD_BEEF, 32'h002081B3, 1'b0);
        xact("CSR",   3'd6, 7'h73, 5'd0, 5'd9, 5'd0, 3'd5, 7'd0, 12'h300, 32'd5,       32'h3002D073, 1'b0);
        xact("Imin",  3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 12'd0, 32'hFFFF_F800, 32'h80000093, 1'b0);
        xact("Bmax",  3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 12'd0, 32'd4094,      32'h7E000FE3, 1'b0);
        xact("Jmax",  3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 12'd0, 32'd1048574,   32'h7FFFF0EF, 1'b0);
        chk("cnt.enc10", 32'(enc_count), 32'd10);
        chk("cnt.err0", 32'(err_count), 32'd0);

        // Unrepresentable immediates and illegal selector
        xact("Iover", 3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 12'd0, 32'd2048,      32'h80000093, 1'b1);
        chk("cnt.err1", 32'(err_count), 32'd1);
        xact("Bodd",  3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 12'd0, 32'd5,         32'h00000263, 1'b1);
        xact("Bover", 3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 12'd0, 32'd4096,      32'h80000063, 1'b1);
        xact("Ulow",  3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 12'd0, 32'h0000_1001, 32'h000012B7, 1'b1);
        xact("CSRov", 3'd6, 7'h73, 5'd0, 5'd0, 5'd0, 3'd5, 7'd0, 12'h300, 32'd32,      32'h30005073, 1'b1);
        xact("ILL",   3'd7, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 12'd0, 32'd0,         32'h00000013, 1'b1);
        chk("cnt.enc16", 32'(enc_count), 32'd16);
        chk("cnt.err6", 32'(err_count), 32'd6);

        // Asynchronous reset between edges while a word is stalled at the output
        out_ready = 1'b0;
        set_f(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 12'd0, 32'd7);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("pre_rst.valid", 32'(out_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst.out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst.enc_count", 32'(enc_count), 32'd0);
        chk("mid_rst.err_count", 32'(err_count), 32'd0);
        chk("mid_rst.out_inst", out_inst, 32'd0);
        #3;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst.valid", 32'(out_valid), 32'd0);

        // Backpressure: three back-to-back bundles with the output stalled
        set_f(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 12'd0, 32'd1);
        in_valid = 1'b1;
        chk("bp.rdyA", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        set_f(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 12'd0, 32'd2);
        chk("bp.rdyB", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        set_f(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 12'd0, 32'd3);
        chk("bp.rdyC", 32'(in_ready), 32'd0);
        chk("bp.validA", 32'(out_valid), 32'd1);
        chk("bp.instA", out_inst, 32'h00100093);
        @(posedge clk); #1;
        chk("bp.stall_rdy", 32'(in_ready), 32'd0);
        chk("bp.stable", out_inst, 32'h00100093);
        out_ready = 1'b1;
        #1;
        chk("bp.rdy_drain", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("bp.instB", out_inst, 32'h00200093);
        chk("bp.enc1", 32'(enc_count), 32'd1);
        @(posedge clk); #1;
        chk("bp.instC", out_inst, 32'h00300093);
        chk("bp.validC", 32'(out_valid), 32'd1);
        @(posedge clk); #1;
        chk("bp.empty", 32'(out_valid), 32'd0);
        chk("bp.enc3", 32'(enc_count), 32'd3);
        chk("bp.err0", 32'(err_count), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
